// File: rtl/prime_sched_pkg.sv
// Shared definitions for the prime test scheduler: FSM encoding, default sizes,
// and the trivial-candidate classifier used at request accept time.
// Contents: DEFAULT_WIDTH, DEFAULT_TIMEOUT_CYCLES, ST_* encodings, state_t, classify_trivial().
package prime_sched_pkg;

  localparam int DEFAULT_WIDTH          = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT    = ST_WAIT,
    RESPOND = ST_RESPOND
  } state_t;

  // Returns {is_trivial, verdict}. Takes "n < 4" plus the two low bits of n so
  // the function stays independent of the operand width.
  function automatic logic [1:0] classify_trivial(input logic below4, input logic [1:0] low2);
    logic [1:0] r;
    r = 2'b00;
    if (below4) begin
      // 0,1 -> not prime; 2,3 -> prime: the verdict is simply bit 1.
      r = {1'b1, low2[1]};
    end else if (!low2[0]) begin
      r = 2'b10;
    end
    return r;
  endfunction

endpackage

// File: rtl/prime_test_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request searching upward from ptr, wrapping.
// Latency: purely combinational. Backpressure: none, the caller owns the pointer register.
// Ports: req (requests), ptr (search start), grant (one-hot), grant_idx (binary), any (some request set).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant_idx = jj;
        grant[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prime_test_scheduler.sv
// Shares one modexp engine among NUM_REQ Fermat-test requesters; trivial n answered locally.
// Latency: trivial accept->rsp 1 cycle; engine path accept->eng_start 1, eng_done->rsp 1, timeout after TIMEOUT_CYCLES.
// Backpressure: one request in flight; no accept until the response handshake; rsp held until rsp_ready[g].
// Ports: req_valid/req_ready/req_n/req_a per requester; rsp_valid per requester with shared rsp_prime/rsp_timeout;
// eng_start/eng_base/eng_exponent/eng_mod to the engine, eng_done/eng_result back.
module prime_test_scheduler
  import prime_sched_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_n,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic                     rsp_prime,
  output logic                     rsp_timeout,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_base,
  output logic [WIDTH-1:0]         eng_exponent,
  output logic [WIDTH-1:0]         eng_mod,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, gnt_q, arb_idx;
  logic [NUM_REQ-1:0] arb_grant, gnt_oh_q;
  logic               arb_any;
  logic [TMR_W-1:0]   timer;
  logic [WIDTH-1:0]   sel_n, sel_a;
  logic [1:0]         triv;
  logic               accept, done_hit, tmo_hit, rsp_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Operands of the granted requester.
  always_comb begin
    sel_n = '0;
    sel_a = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_n = req_n[i*WIDTH +: WIDTH];
        sel_a = req_a[i*WIDTH +: WIDTH];
      end
    end
  end

  // Classifying at accept time lets a trivial verdict be registered in the
  // same edge, giving rsp_valid one cycle after accept.
  assign triv = classify_trivial(sel_n[WIDTH-1:2] == '0, sel_n[1:0]);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so req_ready reads 0 while reset is held.
        if (reset) begin
          req_ready = arb_grant;
          accept    = arb_any;
          if (arb_any) state_nxt = triv[1] ? RESPOND : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // eng_done takes priority over a coincident timeout.
        if (eng_done) begin
          done_hit  = 1'b1;
          state_nxt = RESPOND;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready[gnt_q]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr       <= '0;
      gnt_q        <= '0;
      gnt_oh_q     <= '0;
      timer        <= '0;
      rsp_valid    <= '0;
      rsp_prime    <= 1'b0;
      rsp_timeout  <= 1'b0;
      eng_start    <= 1'b0;
      eng_base     <= '0;
      eng_exponent <= '0;
      eng_mod      <= '0;
    end else begin
      eng_start <= 1'b0;

      if (accept) begin
        gnt_q    <= arb_idx;
        gnt_oh_q <= arb_grant;
        if (triv[1]) begin
          rsp_valid   <= arb_grant;
          rsp_prime   <= triv[0];
          rsp_timeout <= 1'b0;
        end else begin
          // Operand registers double as the n/a latches; they hold until the next engine accept.
          eng_start    <= 1'b1;
          eng_base     <= sel_a;
          eng_mod      <= sel_n;
          eng_exponent <= sel_n - WIDTH'(1);
        end
      end

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);

      if (done_hit) begin
        rsp_valid   <= gnt_oh_q;
        rsp_prime   <= (eng_result == WIDTH'(1));
        rsp_timeout <= 1'b0;
      end

      if (tmo_hit) begin
        rsp_valid   <= gnt_oh_q;
        rsp_prime   <= 1'b0;
        rsp_timeout <= 1'b1;
      end

      if (rsp_hs) begin
        rsp_valid   <= '0;
        rsp_prime   <= 1'b0;
        rsp_timeout <= 1'b0;
        rr_ptr      <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prime_test_scheduler.sv
// Directed self-checking bench for prime_test_scheduler (WIDTH=16, NUM_REQ=2, TIMEOUT_CYCLES=16).
// Inputs driven 1 time unit after the rising edge; outputs checked there too.
module tb_prime_test_scheduler;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int TC = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_n, req_a;
  logic           rsp_prime, rsp_timeout, eng_start, eng_done;
  logic [W-1:0]   eng_base, eng_exponent, eng_mod, eng_result;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prime_test_scheduler #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TC)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_n        (req_n),
    .req_a        (req_a),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_prime    (rsp_prime),
    .rsp_timeout  (rsp_timeout),
    .eng_start    (eng_start),
    .eng_base     (eng_base),
    .eng_exponent (eng_exponent),
    .eng_mod      (eng_mod),
    .eng_done     (eng_done),
    .eng_result   (eng_result)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 2'b11;
    req_n = {16'd13, 16'd13}; req_a = {16'd2, 16'd2};
    tick; tick;
    tests++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    tests++; if ({eng_start, rsp_prime, rsp_timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {eng_start, rsp_prime, rsp_timeout}); end
    tests++; if ({eng_base, eng_exponent, eng_mod} !== 48'd0) begin errors++; $display("FAIL reset_operands: got %h want 0", {eng_base, eng_exponent, eng_mod}); end
    req_valid = 2'b00; reset = 1'b1;
    tick;
    tests++; if ({req_ready, eng_start, rsp_valid} !== 5'b0) begin errors++; $display("FAIL reset_release_idle: got %b want 0", {req_ready, eng_start, rsp_valid}); end
  endtask

  task automatic test_engine_prime;
    req_n[0 +: W] = 16'd13; req_a[0 +: W] = 16'd2; req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL prime_req_ready: got %b want 01", req_ready); end
    tick; req_valid = 2'b00;
    tests++; if (eng_start !== 1'b1) begin errors++; $display("FAIL prime_eng_start: got %b want 1", eng_start); end
    tests++; if ({eng_base, eng_exponent, eng_mod} !== {16'd2, 16'd12, 16'd13}) begin errors++; $display("FAIL prime_operands: got %0d %0d %0d want 2 12 13", eng_base, eng_exponent, eng_mod); end
    tick;
    tests++; if (eng_start !== 1'b0) begin errors++; $display("FAIL prime_start_pulse: got %b want 0", eng_start); end
    repeat (9) tick;
    eng_done = 1'b1; eng_result = 16'd1;
    tests++; if (rsp_valid !== 2'b00 || eng_mod !== 16'd13) begin errors++; $display("FAIL prime_wait_hold: got %b %0d want 00 13", rsp_valid, eng_mod); end
    tick; eng_done = 1'b0;
    tests++; if ({rsp_valid, rsp_prime, rsp_timeout} !== 4'b0110) begin errors++; $display("FAIL prime_rsp: got %b want 0110", {rsp_valid, rsp_prime, rsp_timeout}); end
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL prime_rsp_clear: got %b want 00", rsp_valid); end
  endtask

  task automatic test_engine_composite;
    req_n[W +: W] = 16'd15; req_a[W +: W] = 16'd2; req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b10) begin errors++; $display("FAIL comp_req_ready: got %b want 10", req_ready); end
    tick; req_valid = 2'b00;
    tests++; if ({eng_start, eng_exponent, eng_mod} !== {1'b1, 16'd14, 16'd15}) begin errors++; $display("FAIL comp_issue: got %b %0d %0d want 1 14 15", eng_start, eng_exponent, eng_mod); end
    tick; tick;
    eng_done = 1'b1; eng_result = 16'd4;
    tick; eng_done = 1'b0;
    tests++; if ({rsp_valid, rsp_prime, rsp_timeout} !== 4'b1000) begin errors++; $display("FAIL comp_rsp: got %b want 1000", {rsp_valid, rsp_prime, rsp_timeout}); end
    rsp_ready = 2'b01; tick;
    tests++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL comp_other_ready_ignored: got %b want 10", rsp_valid); end
    rsp_ready = 2'b10; tick; rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL comp_rsp_clear: got %b want 00", rsp_valid); end
  endtask

  task automatic test_trivial;
    logic [4:0] exp_p;
    exp_p = 5'b01100;  // bit v = expected verdict for n = v
    for (int v = 0; v < 5; v++) begin
      req_n[0 +: W] = W'(v); req_a[0 +: W] = 16'd2; req_valid = 2'b01;
      #1;
      tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL triv_req_ready n=%0d: got %b want 01", v, req_ready); end
      tick; req_valid = 2'b00;
      tests++; if (eng_start !== 1'b0) begin errors++; $display("FAIL triv_no_start n=%0d: got %b want 0", v, eng_start); end
      tests++; if ({rsp_valid, rsp_prime, rsp_timeout} !== {2'b01, exp_p[v], 1'b0}) begin errors++; $display("FAIL triv_rsp n=%0d: got %b want %b", v, {rsp_valid, rsp_prime, rsp_timeout}, {2'b01, exp_p[v], 1'b0}); end
      rsp_ready = 2'b01; tick; rsp_ready = 2'b00;
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g;
    req_valid = 2'b00; reset = 1'b0; tick; reset = 1'b1;
    req_n = {16'd13, 16'd13}; req_a = {16'd2, 16'd2}; req_valid = 2'b11;
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (req_ready !== exp_g) begin errors++; $display("FAIL b2b_grant r=%0d: got %b want %b", r, req_ready, exp_g); end
      tick;
      tests++; if (eng_start !== 1'b1) begin errors++; $display("FAIL b2b_start r=%0d: got %b want 1", r, eng_start); end
      tick; eng_done = 1'b1; eng_result = 16'd1;
      tick; eng_done = 1'b0;
      tests++; if ({rsp_valid, rsp_prime} !== {exp_g, 1'b1}) begin errors++; $display("FAIL b2b_rsp r=%0d: got %b want %b", r, {rsp_valid, rsp_prime}, {exp_g, 1'b1}); end
      if (r == 0) begin
        for (int s = 0; s < 5; s++) begin
          tick;
          tests++; if ({rsp_valid, rsp_prime, rsp_timeout, req_ready, eng_start} !== 7'b0110000) begin errors++; $display("FAIL b2b_stall s=%0d: got %b want 0110000", s, {rsp_valid, rsp_prime, rsp_timeout, req_ready, eng_start}); end
        end
      end
      rsp_ready = exp_g; tick; rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout;
    req_n[0 +: W] = 16'd13; req_a[0 +: W] = 16'd2; req_valid = 2'b01;
    tick; req_valid = 2'b00;
    tests++; if (eng_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", eng_start); end
    repeat (TC) tick;
    tests++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL tmo_early: got %b want 00", rsp_valid); end
    tick;
    tests++; if ({rsp_valid, rsp_prime, rsp_timeout} !== 4'b0101) begin errors++; $display("FAIL tmo_rsp: got %b want 0101", {rsp_valid, rsp_prime, rsp_timeout}); end
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00;
    tick; tick;
    eng_done = 1'b1; eng_result = 16'd1;
    tick; eng_done = 1'b0;
    tests++; if ({rsp_valid, rsp_timeout, eng_start} !== 4'b0000) begin errors++; $display("FAIL tmo_late_done: got %b want 0000", {rsp_valid, rsp_timeout, eng_start}); end
    req_n[0 +: W] = 16'd7; req_a[0 +: W] = 16'd3; req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tmo_next_ready: got %b want 01", req_ready); end
    tick; req_valid = 2'b00;
    tests++; if ({eng_start, eng_base, eng_exponent, eng_mod} !== {1'b1, 16'd3, 16'd6, 16'd7}) begin errors++; $display("FAIL tmo_next_issue: got %b %0d %0d %0d want 1 3 6 7", eng_start, eng_base, eng_exponent, eng_mod); end
    tick; eng_done = 1'b1; eng_result = 16'd1;
    tick; eng_done = 1'b0;
    tests++; if ({rsp_valid, rsp_prime, rsp_timeout} !== 4'b0110) begin errors++; $display("FAIL tmo_next_rsp: got %b want 0110", {rsp_valid, rsp_prime, rsp_timeout}); end
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00;
  endtask

  task automatic test_reset_wait;
    req_n[0 +: W] = 16'd13; req_a[0 +: W] = 16'd2; req_valid = 2'b01;
    tick; req_valid = 2'b00;
    tick; tick;
    reset = 1'b0; tick; reset = 1'b1;
    tests++; if ({rsp_valid, eng_start, rsp_prime, rsp_timeout, req_ready} !== 7'b0) begin errors++; $display("FAIL rstw_flags: got %b want 0", {rsp_valid, eng_start, rsp_prime, rsp_timeout, req_ready}); end
    tests++; if ({eng_base, eng_exponent, eng_mod} !== 48'd0) begin errors++; $display("FAIL rstw_operands: got %h want 0", {eng_base, eng_exponent, eng_mod}); end
    eng_done = 1'b1; eng_result = 16'd1;
    tick; eng_done = 1'b0;
    tick; tick;
    tests++; if ({rsp_valid, eng_start} !== 3'b000) begin errors++; $display("FAIL rstw_done_ignored: got %b want 000", {rsp_valid, eng_start}); end
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstw_ptr: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_n = '0; req_a = '0;
    rsp_ready = '0; eng_done = 1'b0; eng_result = '0;
    #1;
    test_reset;
    test_engine_prime;
    test_engine_composite;
    test_trivial;
    test_back_to_back;
    test_timeout;
    test_reset_wait;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/prime_test_scheduler.md
# prime_test_scheduler

Sequencing controller that shares one multi-cycle modular-exponentiation engine among `NUM_REQ` primality-test requesters, such as the p and q candidate generators in key generation. Each request is a Fermat test of candidate `n` with base `a`. The block arbitrates round-robin, resolves trivial candidates without the engine, and issues `a^(n-1) mod n` to the engine. It returns a prime/not-prime verdict per requester and guards every engine operation with a watchdog timeout.

## Interface
Parameters:
- `WIDTH`, 64, operand width.
- `NUM_REQ`, 2, number of requesters (≥2).
- `TIMEOUT_CYCLES`, 4096, maximum engine cycles, counted from `eng_start`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept strobe.
- `req_n`  in  NUM_REQ*WIDTH  candidate n; slice i belongs to requester i.
- `req_a`  in  NUM_REQ*WIDTH  Fermat base a; slice i belongs to requester i.
- `rsp_valid`  out  NUM_REQ  verdict valid for requester i.
- `rsp_ready`  in  NUM_REQ  requester i consumes the verdict.
- `rsp_prime`  out  1  verdict; qualified by the asserted `rsp_valid` bit.
- `rsp_timeout`  out  1  engine timed out; `rsp_prime` is then 0.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_base`, `eng_exponent`, `eng_mod`  out  WIDTH each  engine operands: a, n−1, n.
- `eng_done`  in  1  one-cycle engine completion pulse.
- `eng_result`  in  WIDTH  engine result; valid when `eng_done` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - Grant g is the first requester with `req_valid` set, searching upward from `rr_ptr` and wrapping.
  - `req_ready[g]` is driven combinationally, only in IDLE and only for g. Accept occurs on `req_valid[g] && req_ready[g]`.
  - On accept, latch n, a and g.
  - Classify the latched candidate:
    - n<2: not prime.
    - n==2 or n==3: prime.
    - n even: not prime.
  - A trivial candidate goes directly to RESPOND. Any other candidate goes to ISSUE.
- **ISSUE**
  - Assert `eng_start` for exactly one cycle and clear the timer. Next state is WAIT.
  - Operands are `eng_base`=a, `eng_exponent`=n−1, `eng_mod`=n. They are driven from the latches and held stable from ISSUE until leaving WAIT.
- **WAIT**
  - Timer increments each cycle.
  - On `eng_done`: prime = (`eng_result`==1), timeout=0, go to RESPOND.
  - Otherwise, when timer == TIMEOUT_CYCLES−1: prime=0, timeout=1, go to RESPOND.
  - If `eng_done` arrives in the same cycle as the timeout, `eng_done` wins.
- **RESPOND**
  - Hold `rsp_valid[g]`=1 and keep `rsp_prime`/`rsp_timeout` stable until `rsp_ready[g]`.
  - On the handshake: `rr_ptr` ← (g+1) mod NUM_REQ, then go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `eng_done` outside WAIT is ignored, including a late done after a timeout.
- Only one request is in flight at a time. No new accept occurs until the response handshake completes.
- Width rules:
  - n−1 is computed in WIDTH bits.
  - n=0 never reaches the engine, so no underflow is issued.
  - The timer is `$clog2(TIMEOUT_CYCLES)+1` bits wide.

## Timing
- Reset values (next edge with `reset`=0): state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_prime`=0, `rsp_timeout`=0, `eng_start`=0, operand outputs 0, timer 0.
- Reset during ISSUE, WAIT or RESPOND aborts the operation. No response is produced. A subsequent `eng_done` is ignored because the FSM is in IDLE.
- Trivial path: accept at cycle T → `rsp_valid` high at T+1.
- Engine path:
  - Accept at T → `eng_start` at T+1.
  - `eng_done` at cycle D → `rsp_valid` at D+1.
  - Timeout → `rsp_valid` at T+1+TIMEOUT_CYCLES+1 (the `eng_start` cycle plus TIMEOUT_CYCLES cycles).
- Earliest re-accept: the cycle after the response handshake. Steady state for trivial requests is one request per 2 cycles, plus any `rsp_ready` stall.
- `req_ready` is combinational from `req_valid` and `rr_ptr`. All other outputs are registered.

## Structure
- Shared package/include `prime_sched_pkg`:
  - FSM state encoding localparams.
  - Default WIDTH and TIMEOUT_CYCLES.
  - A trivial-classification function returning {is_trivial, verdict}.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant`, binary `grant_idx`, `any`.
  - Purely combinational. The pointer register stays in the scheduler.

## Test plan
- Req0 n=13, a=2; engine returns 1 after 10 cycles → `eng_start` 1 cycle after accept with operands (2, 12, 13); `rsp_valid[0]`=1, `rsp_prime`=1, `rsp_timeout`=0 at done+1.
- Req1 n=15, a=2; engine returns 4 → `rsp_prime`=0 on requester 1, `rsp_timeout`=0.
- Req0 n=0, 1, 2, 3, 4 in sequence → no `eng_start`; verdicts 0, 0, 1, 1, 0, each at accept+1.
- Both requesters valid continuously after reset with engine-path n=13; `rsp_ready[0]` held low for 5 cycles on the first response → grant order 0, 1, 0, 1; response 0 stable during the stall; no accept occurs during the stall.
- TIMEOUT_CYCLES=16, engine never completes → `rsp_timeout`=1, `rsp_prime`=0 exactly 17 cycles after `eng_start`; `eng_done` injected 3 cycles later is ignored; the next request proceeds normally.
- `reset` low for 1 cycle during WAIT → all outputs at reset values on the next edge, `rr_ptr`=0; an `eng_done` after reset produces no `rsp_valid`.
